mesa_uart_prm: RTL and testbench
================================

MESA_UART_PRM -- requirements
Module: mesa_uart_prm

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter RX_DEPTH, default 16, RX FIFO entries; a power of 2 and at least 2.
REQ-003 SHALL have parameter TX_DEPTH, default 16, TX FIFO entries; a power of 2 and at least 2.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 baud_div  in  16  bit period in clk cycles, minus 1.
REQ-007 parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
REQ-008 stop2  in  1  1 selects two stop bits on TX; RX checks only the first stop bit.
REQ-009 rxd  in  1  async serial input, idle high.
REQ-010 txd  out  1  registered serial output, idle high.
REQ-011 tx_data  in  DATA_BITS  byte to send; tx_valid  in  1; tx_ready  out  1 (TX FIFO not full).
REQ-012 rx_data  out  DATA_BITS  head of RX FIFO; rx_valid  out  1; rx_ready  in  1.
REQ-013 rx_frame_err, rx_par_err  out  1 each  flags stored with and aligned to rx_data.
REQ-014 rx_overrun  out  1  sticky overrun flag; overrun_clr  in  1 clears it.
REQ-015 rx_level  out  clog2(RX_DEPTH)+1  current RX FIFO occupancy; tx_idle  out  1.

Function
REQ-016 A transfer SHALL occur on any cycle where valid and ready are both high.
REQ-017 A baud_div value below 3 SHALL be treated as 3; each bit lasts baud_div+1 cycles.
REQ-018 The TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP and transmit the frame as: start 0, data LSB first, optional parity, then 1 or 2 stop bits of 1.
REQ-019 TX SHALL latch baud_div, parity_mode and stop2 at entry to START; changes during a frame SHALL take effect on the next frame.
REQ-020 When a word is accepted into an empty TX FIFO with the FSM in IDLE at cycle N, txd SHALL fall at cycle N+2.
REQ-021 Consecutive frames SHALL be sent back-to-back, with no idle bit between the last stop bit and the next start bit.
REQ-022 Even parity SHALL make the count of ones across data plus parity even; odd parity SHALL make it odd.
REQ-023 tx_idle SHALL be high when the TX FIFO is empty, the FSM is in IDLE, and txd is 1.
REQ-024 rxd SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1.
REQ-025 The RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-026 A synchronized 1->0 edge SHALL move the RX FSM from IDLE to START.
REQ-027 RX SHALL sample the line (baud_div>>1) cycles after the start edge; if the sample is 1, it SHALL treat this as a false start and return to IDLE with no write.
REQ-028 After a valid start sample, RX SHALL sample each following bit one full period after the previous sample.
REQ-029 On the stop sample, RX SHALL write {data, frame_err = (stop==0), par_err} to the RX FIFO; par_err SHALL be 0 when parity_mode selects none.
REQ-030 rx_valid SHALL assert on the cycle after the stop-sample write.
REQ-031 After a stop sample, RX SHALL return to IDLE and require a new 1->0 edge, so a held-low break yields exactly one entry: data 0 with frame_err=1.
REQ-032 A write to a full RX FIFO SHALL be dropped and SHALL set rx_overrun, unless a pop occurs in the same cycle, in which case the write SHALL be accepted.
REQ-033 If overrun_clr and an overrun occur in the same cycle, rx_overrun SHALL be set (set wins).
REQ-034 Each FIFO SHALL support simultaneous push and pop at any occupancy, including empty to pass-through after one cycle; read and write pointers SHALL wrap modulo depth.

Reset
REQ-035 While reset_n=0: txd=1, tx_ready=0, rx_valid=0, rx_overrun=0, rx_level=0, tx_idle=1, both FSMs in IDLE, and both FIFOs empty.
REQ-036 tx_ready SHALL rise on the first cycle after reset_n=1.
REQ-037 A reset during a frame SHALL abort it: txd=1 on the next edge, and no partial RX entry is written.

Structure
REQ-038 Package mesa_uart_pkg SHALL hold the parity codes, the FSM state encodings, and MIN_DIV=3.
REQ-039 Sub-module mesa_sync_fifo (parameters WIDTH, DEPTH) SHALL be instantiated once for TX and once for RX; RX width is DATA_BITS+2.

Verification
REQ-040 Loopback 8N1 with baud_div=9: send 0x55 -> txd low 10 cycles then alternating 1/0 bits of 10 cycles each; receive rx_data=0x55 with both error flags 0.
REQ-041 8E1 with data 0x07 -> parity bit 1; force the parity bit to 0 on rxd -> entry 0x07 with rx_par_err=1.
REQ-042 Hold rxd low for 30 bit periods, then high -> exactly one entry: data 0x00, frame_err=1.
REQ-043 RX_DEPTH=4 with rx_ready=0: receive 5 frames -> rx_level=4, rx_overrun=1, first 4 bytes kept; pulse overrun_clr -> rx_overrun=0.
REQ-044 baud_div=9 with a 3-cycle low glitch on rxd -> no entry; assert reset_n=0 mid TX frame -> txd=1 on the next edge and tx_idle=1.

Source files
------------

// File: rtl/mesa_uart_prm_pkg.sv
// rtl/mesa_uart_prm_pkg.sv - shared parity codes, FSM states and divisor helpers for the UART
package mesa_uart_pkg;

  localparam logic [1:0]  PAR_NONE = 2'b00;
  localparam logic [1:0]  PAR_EVEN = 2'b01;
  localparam logic [1:0]  PAR_ODD  = 2'b10;
  localparam logic [15:0] MIN_DIV  = 16'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  // Code 2'b11 behaves like PAR_NONE.
  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/mesa_uart_prm_if.sv
// rtl/mesa_uart_prm_if.sv - TX/RX word handshake bundle between the UART and its user
interface mesa_uart_prm_if #(parameter int DATA_BITS = 8);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_par_err;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_par_err
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_par_err
  );

endinterface

// File: rtl/mesa_uart_prm_fifo.sv
// rtl/mesa_uart_prm_fifo.sv - synchronous FIFO with push/pop in the same cycle at any occupancy
module mesa_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mesa_uart_prm.sv
// rtl/mesa_uart_prm.sv - UART with parity, TX/RX FIFOs and sticky RX overrun
module mesa_uart_prm
  import mesa_uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [15:0]               baud_div,
  input  logic [1:0]                parity_mode,
  input  logic                      stop2,
  input  logic                      rxd,
  output logic                      txd,
  mesa_uart_prm_if.slave            bus,
  output logic                      rx_overrun,
  input  logic                      overrun_clr,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      tx_idle
);

  localparam int TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int RX_LW = $clog2(RX_DEPTH) + 1;
  localparam logic [TX_LW-1:0] TX_FULL  = TX_LW'(TX_DEPTH);
  localparam logic [RX_LW-1:0] RX_FULL  = RX_LW'(RX_DEPTH);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_empty;
  logic [TX_LW-1:0]     tx_level;
  logic                 tx_push;
  logic                 tx_pop;

  logic [DATA_BITS+1:0] rx_wdata;
  logic [DATA_BITS+1:0] rx_head;
  logic                 rx_empty;
  logic                 rx_wr;
  logic                 rx_pop;
  logic                 rx_full;

  uart_state_e          tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d;
  logic [15:0]          tx_div_q, tx_div_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_en_q, tx_par_en_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_stop2_q, tx_stop2_d;
  logic                 tx_second_q, tx_second_d;
  logic                 txd_q, txd_d;
  logic                 rdy_q, rdy_d;
  logic                 tx_tick;
  logic                 tx_load;

  uart_state_e          rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d;
  logic [15:0]          rx_div_q, rx_div_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_pbit_q, rx_pbit_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic                 ovr_q, ovr_d;
  logic                 rx_tick;
  logic                 rx_par_err;

  assign tx_push      = bus.tx_valid && bus.tx_ready;
  assign bus.tx_ready = rdy_q && (tx_level != TX_FULL);
  assign txd          = txd_q;
  assign tx_idle      = tx_empty && (tx_state_q == ST_IDLE) && txd_q;

  mesa_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_push),
    .wdata   (bus.tx_data),
    .pop     (tx_pop),
    .rdata   (tx_head),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_en_d = tx_par_en_q;
    tx_par_d    = tx_par_q;
    tx_stop2_d  = tx_stop2_q;
    tx_second_d = tx_second_q;
    txd_d       = txd_q;
    rdy_d       = 1'b1;
    tx_pop      = 1'b0;
    tx_load     = 1'b0;
    tx_tick     = (tx_cnt_q == tx_div_q);
    tx_cnt_d    = tx_tick ? 16'd0 : tx_cnt_q + 16'd1;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = 16'd0;
        tx_load  = !tx_empty;
      end
      ST_START: if (tx_tick) begin
        tx_state_d = ST_DATA;
        tx_bit_d   = 4'd0;
        txd_d      = tx_shift_q[0];
      end
      ST_DATA: if (tx_tick) begin
        if (tx_bit_q == BIT_LAST) begin
          tx_state_d  = tx_par_en_q ? ST_PARITY : ST_STOP;
          txd_d       = tx_par_en_q ? tx_par_q : 1'b1;
          tx_second_d = 1'b0;
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 4'd1;
          txd_d      = tx_shift_q[1];
        end
      end
      ST_PARITY: if (tx_tick) begin
        tx_state_d = ST_STOP;
        txd_d      = 1'b1;
      end
      ST_STOP: if (tx_tick) begin
        if (tx_stop2_q && !tx_second_q) tx_second_d = 1'b1;
        else if (!tx_empty)             tx_load     = 1'b1;
        else                            tx_state_d  = ST_IDLE;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // Frame settings are captured here so mid-frame changes wait for the next frame.
    if (tx_load) begin
      tx_pop      = 1'b1;
      tx_state_d  = ST_START;
      tx_cnt_d    = 16'd0;
      txd_d       = 1'b0;
      tx_shift_d  = tx_head;
      tx_div_d    = eff_div(baud_div);
      tx_par_en_d = parity_en(parity_mode);
      tx_par_d    = (^tx_head) ^ (parity_mode == PAR_ODD);
      tx_stop2_d  = stop2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_div_q    <= MIN_DIV;
      tx_bit_q    <= 4'd0;
      tx_shift_q  <= '0;
      tx_par_en_q <= 1'b0;
      tx_par_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_second_q <= 1'b0;
      txd_q       <= 1'b1;
      rdy_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_en_q <= tx_par_en_d;
      tx_par_q    <= tx_par_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_second_q <= tx_second_d;
      txd_q       <= txd_d;
      rdy_q       <= rdy_d;
    end
  end

  assign rx_par_err = parity_en(parity_mode) &&
                      ((^rx_shift_q) ^ rx_pbit_q ^ (parity_mode == PAR_ODD));
  assign rx_wdata   = {(sync2_q == 1'b0), rx_par_err, rx_shift_q};
  assign rx_pop     = bus.rx_ready && bus.rx_valid;
  assign rx_full    = (rx_level == RX_FULL);
  assign rx_overrun = ovr_q;
  assign bus.rx_valid     = !rx_empty;
  assign bus.rx_frame_err = rx_head[DATA_BITS+1];
  assign bus.rx_par_err   = rx_head[DATA_BITS];
  assign bus.rx_data      = rx_head[DATA_BITS-1:0];

  mesa_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_wr),
    .wdata   (rx_wdata),
    .pop     (rx_pop),
    .rdata   (rx_head),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  always_comb begin
    sync1_d    = rxd;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pbit_d  = rx_pbit_q;
    rx_wr      = 1'b0;
    rx_tick    = (rx_cnt_q == rx_div_q);
    rx_cnt_d   = rx_tick ? 16'd0 : rx_cnt_q + 16'd1;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = 16'd0;
        if (prev_q && !sync2_q) begin
          rx_state_d = ST_START;
          rx_div_d   = eff_div(baud_div);
        end
      end
      // Mid-bit sample of the start bit; a high line here was only a glitch.
      ST_START: if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
        rx_cnt_d   = 16'd0;
        rx_state_d = sync2_q ? ST_IDLE : ST_DATA;
        rx_bit_d   = 4'd0;
      end
      ST_DATA: if (rx_tick) begin
        rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 4'd1;
        if (rx_bit_q == BIT_LAST)
          rx_state_d = parity_en(parity_mode) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (rx_tick) begin
        rx_pbit_d  = sync2_q;
        rx_state_d = ST_STOP;
      end
      ST_STOP: if (rx_tick) begin
        rx_wr      = 1'b1;
        rx_state_d = ST_IDLE;
      end
      default: rx_state_d = ST_IDLE;
    endcase
    ovr_d = (rx_wr && rx_full && !rx_pop) || (ovr_q && !overrun_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= MIN_DIV;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= '0;
      rx_pbit_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pbit_q  <= rx_pbit_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule

// File: tb/tb_mesa_uart_prm.sv
// tb/tb_mesa_uart_prm.sv - directed scoreboard bench for mesa_uart_prm
module tb_mesa_uart_prm;

  localparam int DB  = 8;
  localparam int RXD = 4;
  localparam int TXD = 16;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [15:0]            baud_div = 16'd9;
  logic [1:0]             parity_mode = 2'b00;
  logic                   stop2 = 1'b0;
  logic                   rxd_drv = 1'b1;
  logic                   loop_en = 1'b0;
  logic                   rxd;
  logic                   txd;
  logic                   rx_overrun;
  logic                   overrun_clr = 1'b0;
  logic [$clog2(RXD):0]   rx_level;
  logic                   tx_idle;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  mesa_uart_prm_if #(.DATA_BITS(DB)) bus ();

  assign rxd = loop_en ? txd : rxd_drv;

  mesa_uart_prm #(.DATA_BITS(DB), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .rxd         (rxd),
    .txd         (txd),
    .bus         (bus),
    .rx_overrun  (rx_overrun),
    .overrun_clr (overrun_clr),
    .rx_level    (rx_level),
    .tx_idle     (tx_idle)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns one negedge after the accepting edge (cycle N+1).
  task automatic send(input logic [7:0] d);
    int waited;
    waited = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("tx_accept", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int waited;
    logic [9:0] e;
    waited = 0;
    while (!bus.rx_valid && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
    if (bus.rx_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s_sb observed=unexpected_entry expected=none", tag);
      end else begin
        e = exp_q.pop_front();
        check(tag, 32'({bus.rx_frame_err, bus.rx_par_err, bus.rx_data}), 32'(e));
      end
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd_drv = b;
    step(10);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic with_par, input logic p);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (with_par) drive_bit(p);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  initial begin
    logic [9:0] fr;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    step(3);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    check("rst_level", 32'(rx_level), 32'd0);
    check("rst_tx_idle", 32'(tx_idle), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("tx_ready_rise", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);

    // 8N1 loopback of 0x55 with full waveform check
    loop_en = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h55});
    send(8'h55);
    check("txd_n_plus_1", 32'(txd), 32'd1);
    step(1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 100; c++) begin
      check($sformatf("txd_wave_c%0d", c), 32'(txd), 32'(fr[c / 10]));
      step(1);
    end
    check("txd_after_frame", 32'(txd), 32'd1);
    drain("rx_55");
    check("tx_idle_done", 32'(tx_idle), 32'd1);

    // 8E1: TX parity bit, then a forced bad parity on rxd
    parity_mode = 2'b01;
    exp_q.push_back({1'b0, 1'b0, 8'h07});
    send(8'h07);
    step(1);
    step(95);
    check("tx_parity_bit", 32'(txd), 32'd1);
    step(10);
    check("tx_stop_after_par", 32'(txd), 32'd1);
    drain("rx_07_even");
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    step(5);
    exp_q.push_back({1'b0, 1'b1, 8'h07});
    drive_frame(8'h07, 1'b1, 1'b0);
    drain("rx_07_bad_par");

    // back-to-back frames
    parity_mode = 2'b00;
    loop_en = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'hA3});
    exp_q.push_back({1'b0, 1'b0, 8'h3C});
    send(8'hA3);
    send(8'h3C);
    step(99);
    check("b2b_last_stop", 32'(txd), 32'd1);
    step(1);
    check("b2b_next_start", 32'(txd), 32'd0);
    drain("rx_a3");
    drain("rx_3c");

    // held-low break
    loop_en = 1'b0;
    rxd_drv = 1'b0;
    step(300);
    rxd_drv = 1'b1;
    step(20);
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    drain("rx_break");
    step(200);
    check("break_single_entry", 32'(rx_level), 32'd0);

    // 3-cycle glitch is a false start
    rxd_drv = 1'b0;
    step(3);
    rxd_drv = 1'b1;
    step(200);
    check("glitch_no_entry", 32'(rx_level), 32'd0);
    check("glitch_no_valid", 32'(bus.rx_valid), 32'd0);

    // overrun with RX_DEPTH=4
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({2'b00, 8'(8'h11 * (i + 1))});
      drive_frame(8'(8'h11 * (i + 1)), 1'b0, 1'b0);
    end
    check("ovr_level", 32'(rx_level), 32'd4);
    check("ovr_flag", 32'(rx_overrun), 32'd1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check("ovr_cleared", 32'(rx_overrun), 32'd0);
    drain("rx_ovr0");
    drain("rx_ovr1");
    drain("rx_ovr2");
    drain("rx_ovr3");
    check("ovr_drained", 32'(rx_level), 32'd0);

    // reset in the middle of a TX frame
    send(8'h00);
    step(36);
    check("mid_frame_low", 32'(txd), 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_txd", 32'(txd), 32'd1);
    check("abort_tx_idle", 32'(tx_idle), 32'd1);
    check("abort_tx_ready", 32'(bus.tx_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    check("post_rst_ready", 32'(bus.tx_ready), 32'd1);
    check("post_rst_level", 32'(rx_level), 32'd0);
    step(200);
    check("post_rst_txd_idle", 32'(txd), 32'd1);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
